npc_pc_unit: RTL

- Next-PC generator and program-counter register for the single-cycle core, directly downstream of the control decoder.
- Consumes the decoder's 4-bit NPCOp together with instruction fields and register-file read data.
- Resolves branches and jumps, updates PC each clock, and supplies PC+4 for NPC2REG link writes (JAL/JALR).

---
 rtl/npc_pc_unit_pkg.sv | 37 +++
 rtl/npc_pc_unit_if.sv | 53 +++++
 rtl/npc_branch_cmp.sv | 38 +++
 rtl/npc_pc_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/npc_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// npc_pc_unit_pkg
// Shared definitions for the next-PC unit: the 4-bit NPCOp encodings produced
// by the control decoder (same values as ctrl_encode_def.v), the default reset
// PC, and small helpers for branch decoding and offset extension.
// Optional feature macro used by files importing this package: NPC_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package npc_pc_unit_pkg;

   localparam int          ADDR_W_DEF   = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   // Codes not listed here are treated as NPC_PLUS4 by the unit.
   typedef enum logic [3:0] {
      NPC_PLUS4       = 4'd0,
      NPC_BRANCH_BEQ  = 4'd1,
      NPC_JUMP        = 4'd2,
      NPC_JUMPR       = 4'd3,
      NPC_BRANCH_BNE  = 4'd4,
      NPC_BRANCH_BGTZ = 4'd5,
      NPC_BRANCH_BLEZ = 4'd6,
      NPC_BRANCH_BLTZ = 4'd7,
      NPC_BRANCH_BGEZ = 4'd8
   } npc_op_e;

   // True for the six conditional branch codes.
   function automatic logic is_branch(input logic [3:0] op);
      return op inside {NPC_BRANCH_BEQ, NPC_BRANCH_BNE, NPC_BRANCH_BGTZ,
                        NPC_BRANCH_BLEZ, NPC_BRANCH_BLTZ, NPC_BRANCH_BGEZ};
   endfunction

   // Word offset of a branch: sign-extended imm16 shifted left by two.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage

// File: rtl/npc_pc_unit_if.sv
// -----------------------------------------------------------------------------
// npc_pc_unit_if
// Bundles the decoder/datapath-facing signals of the next-PC unit.
//   master : decoder/datapath side - drives stall, NPCOp, imm16, instr_index,
//            rs_data, rt_data; receives PC, pc_plus4, npc, branch_taken,
//            pc_misalign (and instr_cnt/taken_cnt when NPC_PERF_CNT_EN).
//   slave  : the next-PC unit itself.
// Signalling contract: there is no valid/ready pair. Every output is valid
// every cycle; npc and branch_taken are combinational from the current inputs
// and PC, and consumers must qualify them with ~stall. A cycle with stall=1
// does not advance PC or any other state.
// Optional feature macro: NPC_PERF_CNT_EN adds instr_cnt and taken_cnt.
// -----------------------------------------------------------------------------
interface npc_pc_unit_if;

   logic        stall;
   logic [3:0]  NPCOp;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] rs_data;
   logic [31:0] rt_data;

   logic [31:0] PC;
   logic [31:0] pc_plus4;
   logic [31:0] npc;
   logic        branch_taken;
   logic        pc_misalign;
`ifdef NPC_PERF_CNT_EN
   logic [31:0] instr_cnt;
   logic [31:0] taken_cnt;
`endif

`ifdef NPC_PERF_CNT_EN
   modport master (
      output stall, NPCOp, imm16, instr_index, rs_data, rt_data,
      input  PC, pc_plus4, npc, branch_taken, pc_misalign, instr_cnt, taken_cnt
   );
   modport slave (
      input  stall, NPCOp, imm16, instr_index, rs_data, rt_data,
      output PC, pc_plus4, npc, branch_taken, pc_misalign, instr_cnt, taken_cnt
   );
`else
   modport master (
      output stall, NPCOp, imm16, instr_index, rs_data, rt_data,
      input  PC, pc_plus4, npc, branch_taken, pc_misalign
   );
   modport slave (
      input  stall, NPCOp, imm16, instr_index, rs_data, rt_data,
      output PC, pc_plus4, npc, branch_taken, pc_misalign
   );
`endif

endinterface

// File: rtl/npc_branch_cmp.sv
// -----------------------------------------------------------------------------
// npc_branch_cmp
// Combinational branch-condition evaluation for the next-PC unit.
//   NPCOp     in  4   next-PC select
//   rs_data   in  32  GPR[rs] (two's complement for the sign tests)
//   rt_data   in  32  GPR[rt]
//   cond_true out 1   condition of the selected branch holds; 0 for non-branches
// -----------------------------------------------------------------------------
module npc_branch_cmp
   import npc_pc_unit_pkg::*;
(
   input  logic [3:0]  NPCOp,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        cond_true
);

   logic rs_zero;
   logic rs_neg;

   assign rs_zero = ~(|rs_data);
   assign rs_neg  = rs_data[31];

   always_comb begin
      cond_true = 1'b0;
      case (NPCOp)
         NPC_BRANCH_BEQ:  cond_true = (rs_data == rt_data);
         NPC_BRANCH_BNE:  cond_true = (rs_data != rt_data);
         // Signed rs > 0: non-negative and not zero.
         NPC_BRANCH_BGTZ: cond_true = ~rs_neg & ~rs_zero;
         NPC_BRANCH_BLEZ: cond_true = rs_neg | rs_zero;
         NPC_BRANCH_BLTZ: cond_true = rs_neg;
         NPC_BRANCH_BGEZ: cond_true = ~rs_neg;
         default:         cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/npc_pc_unit.sv
// -----------------------------------------------------------------------------
// npc_pc_unit
// Next-PC selection and program-counter register for the single-cycle core.
//   clk  in  core clock, rising edge
//   rst  in  synchronous active-high reset (overrides stall)
//   bus  npc_pc_unit_if.slave:
//        stall, NPCOp, imm16, instr_index, rs_data, rt_data  (inputs)
//        PC (registered), pc_plus4, npc, branch_taken (combinational),
//        pc_misalign (sticky, registered)
//        instr_cnt, taken_cnt (only with NPC_PERF_CNT_EN)
// Parameters: ADDR_W (fixed at 32 for this core), RESET_PC (word aligned).
// Optional feature macro: NPC_PERF_CNT_EN adds retired-cycle and redirect
// counters; without it neither ports nor registers exist.
// No branch delay slot: PC takes npc on the next unstalled edge.
// -----------------------------------------------------------------------------
module npc_pc_unit
   import npc_pc_unit_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
)
(
   input  logic          clk,
   input  logic          rst,
   npc_pc_unit_if.slave  bus
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              pc_misalign_q, pc_misalign_d;

   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] npc;
   logic              taken;
   logic              jumpr_misalign;
   logic              cond_true;

   npc_branch_cmp u_branch_cmp (
      .NPCOp     (bus.NPCOp),
      .rs_data   (bus.rs_data),
      .rt_data   (bus.rt_data),
      .cond_true (cond_true)
   );

   // Both additions wrap silently modulo 2^32.
   assign pc_plus4  = pc_q + ADDR_W'(4);
   assign br_target = pc_plus4 + branch_offset(bus.imm16);

   always_comb begin
      npc            = pc_plus4;
      taken          = 1'b0;
      jumpr_misalign = 1'b0;
      if (is_branch(bus.NPCOp)) begin
         taken = cond_true;
         npc   = cond_true ? br_target : pc_plus4;
      end else begin
         case (bus.NPCOp)
            NPC_JUMP: begin
               taken = 1'b1;
               npc   = {pc_plus4[ADDR_W-1:ADDR_W-4], bus.instr_index, 2'b00};
            end
            NPC_JUMPR: begin
               // Low bits are dropped from the target but remembered as a fault.
               taken          = 1'b1;
               npc            = {bus.rs_data[ADDR_W-1:2], 2'b00};
               jumpr_misalign = |bus.rs_data[1:0];
            end
            default: begin
               npc   = pc_plus4;
               taken = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      pc_d          = pc_q;
      pc_misalign_d = pc_misalign_q;
      if (!bus.stall) begin
         pc_d          = npc;
         pc_misalign_d = pc_misalign_q | jumpr_misalign;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         pc_misalign_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         pc_misalign_q <= pc_misalign_d;
      end
   end

`ifdef NPC_PERF_CNT_EN
   logic [31:0] instr_cnt_q, instr_cnt_d;
   logic [31:0] taken_cnt_q, taken_cnt_d;

   always_comb begin
      instr_cnt_d = instr_cnt_q;
      taken_cnt_d = taken_cnt_q;
      if (!bus.stall) begin
         instr_cnt_d = instr_cnt_q + 32'd1;
         if (taken) taken_cnt_d = taken_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_cnt_q <= 32'd0;
         taken_cnt_q <= 32'd0;
      end else begin
         instr_cnt_q <= instr_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign bus.instr_cnt = instr_cnt_q;
   assign bus.taken_cnt = taken_cnt_q;
`endif

   assign bus.PC           = pc_q;
   assign bus.pc_plus4     = pc_plus4;
   assign bus.npc          = npc;
   assign bus.branch_taken = taken;
   assign bus.pc_misalign  = pc_misalign_q;

endmodule
